// File: rtl/fmap_bank_ctrl.sv
// N-bank feature-map buffer: the writer fills banks round-robin and the reader drains them in the same order.
// Per-bank FREE/FILLING/FULL state provides write backpressure and the read-side frame-ready flag.
module fmap_bank_ctrl #(
  parameter int W_DATA = 128,
  parameter int N_WORD = 4096,
  parameter int W_WORD = 12,
  parameter int N_BANK = 2,
  parameter int W_BANK = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic [W_WORD:0]   frame_len_i,
  input  logic              wr_vld_i,
  input  logic [W_DATA-1:0] wr_data_i,
  output logic              wr_rdy_o,
  input  logic              rd_en_i,
  input  logic [W_WORD-1:0] rd_addr_i,
  output logic [W_DATA-1:0] rd_data_o,
  output logic              rd_data_vld_o,
  input  logic              rd_done_i,
  output logic              frame_rdy_o,
  output logic [W_BANK-1:0] wr_bank_o,
  output logic [W_BANK-1:0] rd_bank_o,
  output logic [2:0]        full_cnt_o,
  output logic              ovf_err_o
);

  localparam int DEPTH  = N_BANK * N_WORD;
  localparam int W_ADDR = $clog2(DEPTH);
  localparam logic [W_WORD:0] NW = (W_WORD+1)'(N_WORD);

  typedef enum logic [1:0] {FREE, FILLING, FULL} bank_st_e;

  bank_st_e          st_q [N_BANK];
  logic [W_BANK-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [W_WORD-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_WORD:0]   len_q, len_d, len_in, len_eff;
  logic              ovf_q;
  logic [W_DATA-1:0] rd_data_q;
  logic              rd_vld_q;
  logic [W_DATA-1:0] mem_q [DEPTH];

  bank_st_e wr_st, rd_st;
  logic     wr_acc, wr_last, rd_acc, rd_rel;

  function automatic logic [W_BANK-1:0] nxt_bank(input logic [W_BANK-1:0] b);
    return (b == W_BANK'(N_BANK-1)) ? '0 : b + W_BANK'(1);
  endfunction

  // Decode the write/read bank states without variable array indexing.
  always_comb begin
    wr_st      = FREE;
    rd_st      = FREE;
    full_cnt_o = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (wr_bank_q == W_BANK'(b)) wr_st = st_q[b];
      if (rd_bank_q == W_BANK'(b)) rd_st = st_q[b];
      full_cnt_o = full_cnt_o + 3'(st_q[b] == FULL);
    end
  end

  assign wr_rdy_o    = (wr_st != FULL);
  assign frame_rdy_o = (rd_st == FULL);

  // A fresh frame uses the live length (clamped); an open frame keeps the latched one.
  assign len_in  = (frame_len_i == '0 || frame_len_i > NW) ? NW : frame_len_i;
  assign len_eff = (wr_st == FREE) ? len_in : len_q;

  assign wr_acc  = wr_vld_i & wr_rdy_o & ~flush_i;
  assign wr_last = ({1'b0, wr_ptr_q} == len_eff - (W_WORD+1)'(1));
  assign rd_acc  = rd_en_i & frame_rdy_o & ~flush_i;
  assign rd_rel  = rd_done_i & frame_rdy_o & ~flush_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    len_d     = len_q;
    if (wr_acc) begin
      wr_ptr_d = wr_last ? '0 : wr_ptr_q + W_WORD'(1);
      if (wr_last) wr_bank_d = nxt_bank(wr_bank_q);
      if (wr_st == FREE) len_d = len_in;
    end
    if (rd_rel) rd_bank_d = nxt_bank(rd_bank_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < N_BANK; b++) st_q[b] <= FREE;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_ptr_q  <= '0;
      len_q     <= NW;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (flush_i) begin
      for (int b = 0; b < N_BANK; b++) st_q[b] <= FREE;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_ptr_q  <= '0;
      len_q     <= NW;
      ovf_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      // Write and read banks never coincide here: one is FULL, the other is not.
      for (int b = 0; b < N_BANK; b++) begin
        if (wr_acc && wr_bank_q == W_BANK'(b))
          st_q[b] <= wr_last ? FULL : FILLING;
        else if (rd_rel && rd_bank_q == W_BANK'(b))
          st_q[b] <= FREE;
      end
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      ovf_q     <= ovf_q | (wr_vld_i & ~wr_rdy_o);
      rd_vld_q  <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q[W_ADDR'({rd_bank_q, rd_addr_i})];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[W_ADDR'({wr_bank_q, wr_ptr_q})] <= wr_data_i;
  end

  assign rd_data_o     = rd_data_q;
  assign rd_data_vld_o = rd_vld_q;
  assign wr_bank_o     = wr_bank_q;
  assign rd_bank_o     = rd_bank_q;
  assign ovf_err_o     = ovf_q;

endmodule

// File: tb/tb_fmap_bank_ctrl.sv
// Two instances (2 and 4 banks) share one stimulus stream; each is compared cycle by cycle with a bank-level
// model, plus directed checks and an in-order scoreboard for the streaming phase.
module tb_fmap_bank_ctrl;
  localparam int WD = 16, NW = 16, WW = 4;

  logic clk = 1'b0;
  logic rstn, flush, wr_vld, rd_en, rd_done;
  logic [WW:0]   frame_len;
  logic [WD-1:0] wr_data;
  logic [WW-1:0] rd_addr;

  logic          wr_rdy [2], frame_rdy [2], rvld [2], ovf [2];
  logic [WD-1:0] rdat [2];
  logic [1:0]    wbk [2], rbk [2];
  logic [2:0]    fcnt [2];

  int checks = 0, errors = 0;

  // Model: bank state 0=free 1=filling 2=full.
  int            bst [2][4];
  int            wb [2], rb [2], wp [2], len [2];
  bit            ovf_m [2], rvld_m [2];
  logic [WD-1:0] rdat_m [2];
  logic [WD-1:0] mem_m [2][4][NW];
  logic [WD-1:0] sb [$];

  always #5 clk = ~clk;

  fmap_bank_ctrl #(.W_DATA(WD), .N_WORD(NW), .W_WORD(WW), .N_BANK(2), .W_BANK(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .flush_i(flush), .frame_len_i(frame_len),
    .wr_vld_i(wr_vld), .wr_data_i(wr_data), .wr_rdy_o(wr_rdy[0]),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdat[0]), .rd_data_vld_o(rvld[0]),
    .rd_done_i(rd_done), .frame_rdy_o(frame_rdy[0]), .wr_bank_o(wbk[0]), .rd_bank_o(rbk[0]),
    .full_cnt_o(fcnt[0]), .ovf_err_o(ovf[0]));

  fmap_bank_ctrl #(.W_DATA(WD), .N_WORD(NW), .W_WORD(WW), .N_BANK(4), .W_BANK(2)) u_dut4 (
    .clk(clk), .rstn(rstn), .flush_i(flush), .frame_len_i(frame_len),
    .wr_vld_i(wr_vld), .wr_data_i(wr_data), .wr_rdy_o(wr_rdy[1]),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdat[1]), .rd_data_vld_o(rvld[1]),
    .rd_done_i(rd_done), .frame_rdy_o(frame_rdy[1]), .wr_bank_o(wbk[1]), .rd_bank_o(rbk[1]),
    .full_cnt_o(fcnt[1]), .ovf_err_o(ovf[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wrdy(input int m);
    return bst[m][wb[m]] != 2;
  endfunction
  function automatic bit m_frdy(input int m);
    return bst[m][rb[m]] == 2;
  endfunction
  function automatic int m_full(input int m);
    int n = 0;
    for (int b = 0; b < 4; b++) if (bst[m][b] == 2) n++;
    return n;
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 4; b++) bst[m][b] = 0;
      wb[m] = 0; rb[m] = 0; wp[m] = 0; len[m] = NW;
      ovf_m[m] = 0; rvld_m[m] = 0; rdat_m[m] = '0;
    end
  endtask

  task automatic mstep(input int m);
    int nb   = (m == 0) ? 2 : 4;
    bit frdy = m_frdy(m);
    bit wrdy = m_wrdy(m);
    if (flush) begin
      for (int b = 0; b < 4; b++) bst[m][b] = 0;
      wb[m] = 0; rb[m] = 0; wp[m] = 0; ovf_m[m] = 0; rvld_m[m] = 0;
      return;
    end
    rvld_m[m] = rd_en && frdy;
    if (rvld_m[m]) rdat_m[m] = mem_m[m][rb[m]][rd_addr];
    if (wr_vld && !wrdy) ovf_m[m] = 1;
    if (wr_vld && wrdy) begin
      if (bst[m][wb[m]] == 0) len[m] = (frame_len == 0 || int'(frame_len) > NW) ? NW : int'(frame_len);
      mem_m[m][wb[m]][wp[m]] = wr_data;
      wp[m]++;
      if (wp[m] == len[m]) begin
        bst[m][wb[m]] = 2; wp[m] = 0; wb[m] = (wb[m] + 1) % nb;
      end else bst[m][wb[m]] = 1;
    end
    if (rd_done && frdy) begin
      bst[m][rb[m]] = 0; rb[m] = (rb[m] + 1) % nb;
    end
  endtask

  task automatic cmp_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("wr_rdy[%0d]", m),    32'(wr_rdy[m]),    32'(m_wrdy(m)));
      chk($sformatf("frame_rdy[%0d]", m), 32'(frame_rdy[m]), 32'(m_frdy(m)));
      chk($sformatf("full_cnt[%0d]", m),  32'(fcnt[m]),      32'(m_full(m)));
      chk($sformatf("wr_bank[%0d]", m),   32'(wbk[m]),       32'(wb[m]));
      chk($sformatf("rd_bank[%0d]", m),   32'(rbk[m]),       32'(rb[m]));
      chk($sformatf("ovf_err[%0d]", m),   32'(ovf[m]),       32'(ovf_m[m]));
      chk($sformatf("rd_vld[%0d]", m),    32'(rvld[m]),      32'(rvld_m[m]));
      chk($sformatf("rd_data[%0d]", m),   32'(rdat[m]),      32'(rdat_m[m]));
    end
  endtask

  task automatic cyc();
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic wbeat(input logic [WD-1:0] d);
    wr_vld = 1'b1; wr_data = d;
    cyc();
    wr_vld = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1; rd_addr = WW'(a);
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic rel();
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
  endtask

  initial begin
    int raddr, frames_r, beats_w;
    logic [WD-1:0] exp_d;
    rstn = 1'b0; flush = 1'b0; wr_vld = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    frame_len = 5'd4; wr_data = '0; rd_addr = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    chk("rst_wr_rdy", 32'(wr_rdy[0]), 32'd1);
    chk("rst_rd_data", 32'(rdat[0]), 32'd0);
    rstn = 1'b1;

    // 4-beat frame, then read it back
    for (int i = 0; i < 4; i++) wbeat(WD'(16'hA0 + i));
    chk("t1_frame_rdy", 32'(frame_rdy[0]), 32'd1);
    chk("t1_wr_bank", 32'(wbk[0]), 32'd1);
    chk("t1_full_cnt", 32'(fcnt[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(i);
      chk("t1_rd_data", 32'(rdat[0]), 32'(16'hA0 + i));
      chk("t1_rd_vld", 32'(rvld[0]), 32'd1);
    end

    // both banks full, overflow beat dropped, release
    for (int i = 0; i < 4; i++) wbeat(WD'(16'hB0 + i));
    chk("t2_wr_rdy", 32'(wr_rdy[0]), 32'd0);
    chk("t2_full_cnt", 32'(fcnt[0]), 32'd2);
    wbeat(16'hDEAD);
    chk("t2_ovf", 32'(ovf[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(i);
      chk("t2_bank0_kept", 32'(rdat[0]), 32'(16'hA0 + i));
    end
    rel();
    chk("t2_rel_wr_rdy", 32'(wr_rdy[0]), 32'd1);
    chk("t2_rel_rd_bank", 32'(rbk[0]), 32'd1);

    // 4-bank instance ends up with 2 FULL + 1 FILLING; flush beats same-cycle traffic
    for (int i = 0; i < 4; i++) wbeat(WD'(16'hC0 + i));
    chk("t3_full4", 32'(fcnt[1]), 32'd2);
    flush = 1'b1; wr_vld = 1'b1; rd_en = 1'b1; rd_done = 1'b1;
    cyc();
    flush = 1'b0; wr_vld = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("t3_flush_full_cnt", 32'(fcnt[m]), 32'd0);
      chk("t3_flush_wr_bank", 32'(wbk[m]), 32'd0);
      chk("t3_flush_rd_bank", 32'(rbk[m]), 32'd0);
      chk("t3_flush_wr_rdy", 32'(wr_rdy[m]), 32'd1);
      chk("t3_flush_ovf", 32'(ovf[m]), 32'd0);
      chk("t3_flush_rd_vld", 32'(rvld[m]), 32'd0);
    end

    // read and release with nothing ready
    rd_en = 1'b1; rd_done = 1'b1;
    cyc();
    rd_en = 1'b0; rd_done = 1'b0;
    chk("t4_rd_vld", 32'(rvld[0]), 32'd0);
    chk("t4_rd_bank", 32'(rbk[0]), 32'd0);

    // length latched only at frame start; 0 means full bank
    frame_len = 5'd8;
    for (int i = 0; i < 3; i++) wbeat(WD'($urandom));
    frame_len = 5'd3;
    for (int i = 0; i < 4; i++) wbeat(WD'($urandom));
    chk("t5_len8_open", 32'(fcnt[0]), 32'd0);
    wbeat(WD'($urandom));
    chk("t5_len8_done", 32'(fcnt[0]), 32'd1);
    for (int i = 0; i < 3; i++) wbeat(WD'($urandom));
    chk("t5_len3_done", 32'(fcnt[0]), 32'd2);
    rel();
    rel();
    frame_len = 5'd0;
    for (int i = 0; i < 15; i++) wbeat(WD'($urandom));
    chk("t5_len0_open", 32'(fcnt[0]), 32'd0);
    wbeat(16'h5A5A);
    chk("t5_len0_done", 32'(fcnt[0]), 32'd1);
    rd(15);
    chk("t5_len0_last", 32'(rdat[0]), 32'h5A5A);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // concurrent streams, 10 frames of 16, read in order; last read shares the cycle with rd_done
    frame_len = 5'd16;
    raddr = 0; frames_r = 0; beats_w = 0;
    for (int c = 0; c < 4000 && frames_r < 10; c++) begin
      wr_vld  = (beats_w < 160) && m_wrdy(0) && m_wrdy(1) && ($urandom_range(0, 3) != 0);
      wr_data = WD'($urandom);
      if (wr_vld) begin sb.push_back(wr_data); beats_w++; end
      rd_en = 1'b0; rd_done = 1'b0;
      if (m_frdy(0) && m_frdy(1) && $urandom_range(0, 4) != 0) begin
        rd_en = 1'b1; rd_addr = WW'(raddr);
        if (raddr == NW - 1) begin rd_done = 1'b1; raddr = 0; frames_r++; end
        else raddr++;
      end
      cyc();
      if (rvld_m[1]) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("stream_data", 32'(rdat[1]), 32'(exp_d));
      end
    end
    wr_vld = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    chk("stream_frames", 32'(frames_r), 32'd10);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);
    chk("stream_ovf2", 32'(ovf[0]), 32'd0);
    chk("stream_ovf4", 32'(ovf[1]), 32'd0);

    // async reset while read data is valid
    frame_len = 5'd4;
    for (int i = 0; i < 4; i++) wbeat(WD'($urandom));
    rd_en = 1'b1; rd_addr = 4'd2;
    cyc();
    chk("t7_vld_before", 32'(rvld[0]), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t7_rst_vld2", 32'(rvld[0]), 32'd0);
    chk("t7_rst_vld4", 32'(rvld[1]), 32'd0);
    chk("t7_rst_data", 32'(rdat[0]), 32'd0);
    mreset();
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmap_bank_ctrl.md
# fmap_bank_ctrl

Parametrised N-bank feature-map buffer with bank-state tracking, sitting between a layer engine (conv, max pool, upsample) output and the next layer's input fetch in the AIX YOLOv4 datapath. It generalises the fixed two-buffer ping-pong scheme. Bank count and depth are parameters. Per-frame length is set at run time. Per-bank FREE/FILLING/FULL tracking gives the writer backpressure and the reader a frame-ready indication, so producer and consumer layers overlap without software bank selection.

## Interface
- W_DATA, 128: word width (To*ACT_BITS).
- N_WORD, 4096: words per bank.
- W_WORD, 12: address width, clog2(N_WORD).
- N_BANK, 2: number of banks, legal 2..4.
- W_BANK, 2: bank index width, fixed at 2.
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort: all banks FREE, pointers 0, ovf_err cleared.
- frame_len  in  W_WORD+1  words per frame; sampled on first accepted write into a FREE bank.
- wr_vld  in  1  write beat valid.
- wr_data  in  W_DATA  write data.
- wr_rdy  out  1  current write bank is FREE or FILLING.
- rd_en  in  1  read request for current read bank.
- rd_addr  in  W_WORD  word address within current read bank.
- rd_data  out  W_DATA  registered read data.
- rd_data_vld  out  1  rd_data valid this cycle.
- rd_done  in  1  pulse: release current read bank.
- frame_rdy  out  1  current read bank is FULL.
- wr_bank  out  W_BANK  current write bank index.
- rd_bank  out  W_BANK  current read bank index.
- full_cnt  out  3  number of FULL banks.
- ovf_err  out  1  sticky: wr_vld seen while wr_rdy=0.

## Operation
- Bank state per bank: FREE -> FILLING on first accepted beat; FILLING -> FULL on beat index len-1; FULL -> FREE on rd_done while it is rd_bank.
- A frame of length 1 goes FREE -> FULL directly.
- Storage: N_BANK*N_WORD words, inferred simple dual-port RAM. Write address is {wr_bank, wr_ptr}; read address is {rd_bank, rd_addr}.
- Write accept: wr_vld & wr_rdy. The word is stored at wr_ptr, then wr_ptr increments.
- On the last beat, wr_ptr clears to 0 and wr_bank advances modulo N_BANK.
- Length latch: frame_len is captured into len_q at the FREE -> FILLING transition only. Changes mid-frame are ignored. frame_len=0 or frame_len>N_WORD clamps to N_WORD.
- Read: rd_en & frame_rdy reads RAM. rd_en while frame_rdy=0 is ignored: rd_data_vld=0 and rd_data holds its value.
- rd_addr >= len_q returns stale RAM contents. No error is flagged.
- rd_done & frame_rdy: bank goes FREE and rd_bank advances modulo N_BANK. rd_done while frame_rdy=0 is ignored.
- A read issued in the same cycle as rd_done still completes from the releasing bank.
- Overflow: wr_vld & ~wr_rdy drops the beat and sets ovf_err. ovf_err is cleared only by reset or flush.
- full_cnt = count of banks in FULL, range 0..N_BANK.
- flush has priority over all same-cycle writes, reads and releases. No pending rd_data_vld is produced after flush.

## Timing
- Reset values: all banks FREE, wr_bank=rd_bank=0, wr_ptr=0, len_q=N_WORD.
- Reset output values: wr_rdy=1, rd_data=0, rd_data_vld=0, frame_rdy=0, full_cnt=0, ovf_err=0.
- wr_rdy, frame_rdy and full_cnt decode combinationally from registered bank state. None depends combinationally on wr_vld, rd_en or rd_done.
- Last write beat at edge T: frame_rdy (if it is rd_bank) and full_cnt update after T. wr_rdy after T reflects the next bank's state.
- Read latency is 1: rd_en sampled at edge T gives rd_data/rd_data_vld valid after T, held for one cycle.
- Read-during-write to the same address cannot occur, since a bank cannot be both FULL and FILLING.
- Release at edge T: the bank is FREE after T, and wr_rdy may rise in the cycle after T when that bank is wr_bank. The writer stalls 0 extra cycles beyond this.
- Simultaneous last write into bank k and rd_done on bank j≠k are both applied at the same edge.
- Throughput: 1 write and 1 read per cycle, sustained.

## Test plan
- Reset, N_BANK=2, frame_len=4: write 4 beats 0xA0..0xA3 -> frame_rdy=1 the cycle after beat 3, wr_bank=1, full_cnt=1. Read addr 0..3 -> 0xA0..0xA3 each one cycle later with rd_data_vld=1.
- Fill both banks (len 4) with no rd_done -> wr_rdy=0 and full_cnt=2. Extra wr_vld -> ovf_err=1 and bank data unchanged. rd_done -> wr_rdy=1 next cycle, rd_bank=1.
- N_BANK=4, continuous write and read streams with len 16 for 10 frames -> no ovf_err, every frame read back in order, bank pointers wrap 3->0.
- frame_len changed from 8 to 3 mid-frame -> frame completes at 8 beats. Next frame latches 3. frame_len=0 -> frame of N_WORD beats.
- rd_en and rd_done while frame_rdy=0 -> rd_data_vld=0 and no state change.
- flush with 2 FULL banks and a FILLING bank -> next cycle full_cnt=0, wr_bank=rd_bank=0, wr_rdy=1, ovf_err=0.
- Async reset asserted mid-read -> rd_data_vld=0 immediately.
